// File: rtl/piso_serializer.sv
// Parallel-in, serial-out word serializer.
// Accepts words over valid/ready, buffers one word in a hold register and
// shifts each word out MSB first, one registered bit per clock. An optional
// idle gap of GAP cycles follows every word. `aligned` pulses the cycle after
// the LSB is on sout, when a downstream SIPO holds the complete word.
module piso_serializer #(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_last,
  output logic             aligned,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [BW-1:0] LAST    = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_END = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shifter;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic [BW-1:0]    bitcnt;
  logic [GW-1:0]    gapcnt;

  logic             handshake;
  logic             last_bit;
  logic             boundary;
  logic             load_hold;
  logic             load_din;
  logic [WIDTH-1:0] next_word;

  assign din_ready = !hold_full;
  assign busy      = (state != S_IDLE) || hold_full;

  // Word-boundary decode: a new word may enter the shifter from IDLE, on the
  // last bit when there is no gap, or at the end of the gap count. The hold
  // register always wins over a fresh din so words stay in order.
  always_comb begin
    handshake = din_valid && !hold_full;
    last_bit  = (state == S_SHIFT) && (bitcnt == LAST);
    boundary  = (state == S_IDLE)
             || (last_bit && (GAP == 0))
             || ((state == S_GAP) && (gapcnt == GAP_END));
    load_hold = boundary && hold_full;
    load_din  = boundary && !hold_full && handshake;
    next_word = hold_full ? hold : din;
  end

  // Control FSM, shift datapath, hold register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      shifter    <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      bitcnt     <= '0;
      gapcnt     <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;
      aligned    <= 1'b0;
    end else begin
      aligned    <= sout_last;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_last  <= 1'b0;

      if (state == S_SHIFT) begin
        sout       <= shifter[WIDTH-1];
        sout_valid <= 1'b1;
        sout_last  <= (bitcnt == LAST);
        shifter    <= {shifter[WIDTH-2:0], 1'b0};
        bitcnt     <= bitcnt + 1'b1;
      end

      // A load on the last-bit edge overrides the shift above, so the next
      // word's MSB follows the LSB with no bubble.
      if (load_hold || load_din) begin
        shifter <= next_word;
        bitcnt  <= '0;
        state   <= S_SHIFT;
      end else if (last_bit) begin
        gapcnt <= '0;
        state  <= (GAP > 0) ? S_GAP : S_IDLE;
      end else if (state == S_GAP) begin
        if (gapcnt == GAP_END) begin
          state <= S_IDLE;
        end else begin
          gapcnt <= gapcnt + 1'b1;
        end
      end

      if (handshake && !load_din) begin
        hold      <= din;
        hold_full <= 1'b1;
      end else if (load_hold) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Testbench for piso_serializer: three instances (W4/G0, W4/G2, W8/G0) with a
// per-instance bit scoreboard plus directed cycle-accurate timing checks.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0] a_din;  logic a_v, a_rdy, a_so, a_sv, a_sl, a_al, a_busy;
  logic [3:0] b_din;  logic b_v, b_rdy, b_so, b_sv, b_sl, b_al, b_busy;
  logic [7:0] c_din;  logic c_v, c_rdy, c_so, c_sv, c_sl, c_al, c_busy;

  piso_serializer #(.WIDTH(4), .GAP(0)) u_a (
    .clk(clk), .rst(rst), .din(a_din), .din_valid(a_v), .din_ready(a_rdy),
    .sout(a_so), .sout_valid(a_sv), .sout_last(a_sl), .aligned(a_al), .busy(a_busy));
  piso_serializer #(.WIDTH(4), .GAP(2)) u_b (
    .clk(clk), .rst(rst), .din(b_din), .din_valid(b_v), .din_ready(b_rdy),
    .sout(b_so), .sout_valid(b_sv), .sout_last(b_sl), .aligned(b_al), .busy(b_busy));
  piso_serializer #(.WIDTH(8), .GAP(0)) u_c (
    .clk(clk), .rst(rst), .din(c_din), .din_valid(c_v), .din_ready(c_rdy),
    .sout(c_so), .sout_valid(c_sv), .sout_last(c_sl), .aligned(c_al), .busy(c_busy));

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic rst_seen = 1'b0;
  logic mon_en   = 1'b0;
  logic [3:0] sipo;
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] qc[$];
  logic a_psl = 1'b0, b_psl = 1'b0, c_psl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge sampler: cycle count, reset tracking, downstream SIPO model, and
  // scoreboard pushes (MSB first, LSB tagged last) on every handshake.
  always @(posedge clk) begin
    cyc++;
    rst_seen = rst;
    sipo = {sipo[2:0], a_so};
    if (rst) begin
      qa.delete(); qb.delete(); qc.delete();
    end else begin
      if (a_v && a_rdy) for (int i = 3; i >= 0; i--) qa.push_back({i == 0, a_din[i]});
      if (b_v && b_rdy) for (int i = 3; i >= 0; i--) qb.push_back({i == 0, b_din[i]});
      if (c_v && c_rdy) for (int i = 7; i >= 0; i--) qc.push_back({i == 0, c_din[i]});
    end
  end

  // Output monitors: every valid bit pops the scoreboard; idle cycles must
  // drive zeros; aligned must follow sout_last unless reset intervened.
  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      if (a_sv) begin
        chk("a_bit_expected", 32'(qa.size() != 0), 1);
        if (qa.size() != 0) begin
          e = qa.pop_front();
          chk("a_sout", a_so, e[0]); chk("a_last", a_sl, e[1]);
        end
      end else chk("a_idle_out", {a_so, a_sl}, 0);
      chk("a_aligned", a_al, a_psl && !rst_seen);
      if (b_sv) begin
        chk("b_bit_expected", 32'(qb.size() != 0), 1);
        if (qb.size() != 0) begin
          e = qb.pop_front();
          chk("b_sout", b_so, e[0]); chk("b_last", b_sl, e[1]);
        end
      end else chk("b_idle_out", {b_so, b_sl}, 0);
      chk("b_aligned", b_al, b_psl && !rst_seen);
      if (c_sv) begin
        chk("c_bit_expected", 32'(qc.size() != 0), 1);
        if (qc.size() != 0) begin
          e = qc.pop_front();
          chk("c_sout", c_so, e[0]); chk("c_last", c_sl, e[1]);
        end
      end else chk("c_idle_out", {c_so, c_sl}, 0);
      chk("c_aligned", c_al, c_psl && !rst_seen);
    end
    a_psl = a_sl; b_psl = b_sl; c_psl = c_sl;
  end

  task automatic send(input int sel, input logic [7:0] w, output int e0);
    logic hs;
    e0 = -1;
    case (sel)
      0: begin a_din = w[3:0]; a_v = 1'b1; end
      1: begin b_din = w[3:0]; b_v = 1'b1; end
      default: begin c_din = w; c_v = 1'b1; end
    endcase
    for (int t = 0; t < 50; t++) begin
      hs = (sel == 0) ? a_rdy : (sel == 1) ? b_rdy : c_rdy;
      step();
      if (hs) begin
        e0 = cyc;
        break;
      end
    end
    a_v = 1'b0; b_v = 1'b0; c_v = 1'b0;
    chk("send_accepted", 32'(e0 >= 0), 1);
  endtask

  initial begin
    int e0, start, idx, rel;
    logic hs;
    logic [3:0] w1 = 4'b1011;
    logic [3:0] w3[3] = '{4'hA, 4'h5, 4'hF};
    logic [3:0] w2[2] = '{4'h3, 4'hC};
    logic [7:0] wc = 8'h96;

    rst = 1'b1;
    a_din = '0; a_v = 1'b0; b_din = '0; b_v = 1'b0; c_din = '0; c_v = 1'b0;
    repeat (3) step();
    chk("rst_a_out", {a_so, a_sv, a_sl, a_al, a_busy, a_rdy}, 6'b000001);
    chk("rst_b_out", {b_so, b_sv, b_sl, b_al, b_busy, b_rdy}, 6'b000001);
    chk("rst_c_out", {c_so, c_sv, c_sl, c_al, c_busy, c_rdy}, 6'b000001);
    rst = 1'b0;
    mon_en = 1'b1;
    step();

    // Single word 1011: latency, last flag, aligned, SIPO content, busy.
    send(0, {4'h0, w1}, e0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("single_sout", a_so, w1[4-k]);
      chk("single_valid", a_sv, 1);
      chk("single_last", a_sl, k == 4);
      chk("single_aligned_early", a_al, 0);
    end
    step();
    chk("single_aligned", a_al, 1);
    chk("single_busy", a_busy, 0);
    chk("single_sipo", sipo, w1);
    repeat (3) step();

    // Back-to-back A,5,F with valid held: continuous bits and backpressure.
    idx = 0; start = -1; a_din = w3[0]; a_v = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (start >= 0 && cyc >= start + 13) break;
      hs = a_v && a_rdy;
      step();
      if (hs) begin
        if (idx == 0) start = cyc;
        idx++;
        if (idx < 3) a_din = w3[idx];
        else a_v = 1'b0;
      end
      if (start >= 0 && cyc > start) begin
        rel = cyc - start;
        chk("b2b_valid", a_sv, rel <= 12);
        chk("b2b_aligned", a_al, rel == 5 || rel == 9 || rel == 13);
        chk("b2b_ready", a_rdy, !((rel >= 1 && rel <= 3) || (rel >= 5 && rel <= 7)));
      end
    end
    chk("b2b_words_taken", idx, 3);
    a_v = 1'b0;
    repeat (3) step();

    // GAP=2: two idle cycles between words, aligned 6 cycles apart.
    idx = 0; start = -1; b_din = w2[0]; b_v = 1'b1;
    for (int t = 0; t < 60; t++) begin
      if (start >= 0 && cyc >= start + 11) break;
      hs = b_v && b_rdy;
      step();
      if (hs) begin
        if (idx == 0) start = cyc;
        idx++;
        if (idx < 2) b_din = w2[idx];
        else b_v = 1'b0;
      end
      if (start >= 0 && cyc > start) begin
        rel = cyc - start;
        chk("gap_valid", b_sv, (rel >= 1 && rel <= 4) || (rel >= 7 && rel <= 10));
        chk("gap_aligned", b_al, rel == 5 || rel == 11);
        chk("gap_ready", b_rdy, !(rel >= 1 && rel <= 5));
      end
    end
    chk("gap_words_taken", idx, 2);
    b_v = 1'b0;
    repeat (4) step();

    // Backpressure: din changes every cycle; scoreboard checks order/loss.
    for (int t = 0; t < 30; t++) begin
      a_v = 1'b1;
      a_din = 4'($urandom);
      step();
    end
    a_v = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (!a_busy && !a_sv) break;
      step();
    end
    chk("bp_drained_idle", {a_busy, a_sv}, 0);
    step();
    chk("bp_scoreboard_empty", qa.size(), 0);

    // Reset mid-word with a held word: both discarded, no aligned pulse.
    send(0, 8'h0E, e0);
    a_din = 4'h7; a_v = 1'b1;
    step();
    a_v = 1'b0;
    chk("rst_hold_full", a_rdy, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_out", {a_sv, a_rdy, a_al, a_busy}, 4'b0100);
    for (int t = 0; t < 8; t++) begin
      step();
      chk("rst_no_emit", {a_sv, a_al}, 0);
    end
    chk("rst_scoreboard_empty", qa.size(), 0);

    // WIDTH=8 single word 96.
    send(2, wc, e0);
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("w8_sout", c_so, wc[8-k]);
      chk("w8_last", c_sl, k == 8);
    end
    step();
    chk("w8_aligned", c_al, 1);
    chk("w8_busy", c_busy, 0);
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in, serial-out word serializer that sits directly upstream of the 4-bit SIPO shift register and drives its serial input. It accepts parallel words over a valid/ready handshake, buffers one word, and shifts each word out MSB first, one bit per clock. After WIDTH shifts, the downstream SIPO's q[WIDTH-1:0] holds the word in its original bit order. An `aligned` strobe marks the cycle in which the downstream register holds a complete word.

## Interface

Parameters:
- WIDTH, 4, word width in bits; legal range ≥ 2.
- GAP, 0, idle cycles inserted after every word; legal range ≥ 0.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  WIDTH  parallel word; sampled only on a handshake.
- din_valid  in  1  upstream word valid.
- din_ready  out  1  block can accept a word; equals !hold_full (depends only on registered state).
- sout  out  1  registered serial bit; feeds the SIPO `a` input.
- sout_valid  out  1  sout carries a data bit this cycle.
- sout_last  out  1  sout carries the LSB (last bit) of a word.
- aligned  out  1  one-cycle pulse; the downstream SIPO q holds the full word this cycle.
- busy  out  1  state != IDLE or hold_full.

## Operation

- Handshake: a word transfers on a rising edge with din_valid && din_ready. din is ignored at all other times. Upstream may drop din_valid at any time.
- Storage: a WIDTH-bit shifter, a bit counter (0..WIDTH-1), a gap counter, and a one-entry hold register with a hold_full flag.
- States:
  - IDLE:
    - A handshake loads din directly into the shifter, clears the bit counter, and goes to SHIFT.
    - If hold_full, the hold register moves to the shifter instead and goes to SHIFT.
  - SHIFT:
    - Each cycle drives shifter[WIDTH-1] onto sout (registered) and shifts left.
    - A handshake during SHIFT writes the hold register and sets hold_full.
    - On the last bit with GAP==0:
      - If hold_full, the hold register moves to the shifter and hold_full clears.
      - Else, if a handshake occurs that edge, din loads the shifter directly.
      - Else, go to IDLE.
      - In the first two cases, stay in SHIFT.
    - On the last bit with GAP>0: go to GAP.
  - GAP:
    - Counts GAP cycles with sout=0 and sout_valid=0. Handshakes into the hold register are allowed.
    - At the end of the count, behave as IDLE: load hold or din if available, else go to IDLE.
- Outside SHIFT: sout=0, sout_valid=0, sout_last=0.
- aligned: asserted exactly one cycle after each sout_last cycle, i.e., the cycle after the SIPO captures the LSB.
- Priority: the hold register is always loaded into the shifter before a new din. Words are never reordered or dropped.

## Timing

- Reset values: sout=0, sout_valid=0, sout_last=0, aligned=0, busy=0, din_ready=1, state=IDLE, hold_full=0.
- Reset asserted mid-word or mid-gap: the in-flight word and any held word are discarded. No aligned pulse follows. Outputs take reset values from the next cycle.
- Latency:
  - Handshake at edge E0 in IDLE → MSB on sout in cycle E0+1.
  - LSB on sout in cycle E0+WIDTH.
  - aligned in cycle E0+WIDTH+1.
- Throughput, GAP==0 with input continuously valid: one bit per cycle with no bubble; the next word's MSB immediately follows the previous LSB.
- Throughput, GAP>0: exactly GAP cycles with sout_valid=0 between consecutive words.
- Backpressure: din_ready falls in the cycle after the hold register fills. It rises in the cycle after the hold register transfers to the shifter.
- Simultaneous events: a last-bit cycle with hold empty and a handshake loads din straight into the shifter. aligned for the previous word still pulses on the next cycle.

## Test plan

- Single word, WIDTH=4, GAP=0, din=4'b1011 accepted at edge 0 → sout=1,0,1,1 in cycles 1–4, sout_last in cycle 4, aligned in cycle 5, SIPO q=4'b1011 in cycle 5, busy=0 from cycle 5.
- Back-to-back 4'hA, 4'h5, 4'hF with din_valid held high, GAP=0 → 12 continuous valid bits 1010_0101_1111. din_ready=0 while hold is full. aligned in cycles 5, 9, 13.
- GAP=2, two words 4'h3 and 4'hC → exactly 2 cycles with sout_valid=0 and sout=0 between the words. aligned pulses 4+2 cycles apart.
- Backpressure: din_valid high with din changing every cycle → only values sampled on handshake edges appear on sout, in order, with none lost or duplicated.
- Reset in cycle 2 of word 4'hE with hold holding 4'h7 → from the next cycle: sout_valid=0, din_ready=1, no aligned pulse. Neither 4'hE nor 4'h7 is ever emitted.
- WIDTH=8 single word 8'h96 → sout=1,0,0,1,0,1,1,0 in cycles 1–8, aligned in cycle 9.
